// File: rtl/airlock_plant_if.sv
// Door-command interface between the airlock interlock controller (master)
// and the airlock actuator/plant (slave).
// Optional macro: AIRLOCK_OBSTRUCT_EN adds the obstruct/obstruct_fault pair.
interface airlock_plant_if;
  logic [2:0] doorCommand;
  logic [1:0] doors;
  logic       pressurize;
  logic       depressurize;
  logic       busy;
  logic       cmd_reject;
`ifdef AIRLOCK_OBSTRUCT_EN
  logic       obstruct;
  logic       obstruct_fault;

  modport master (
    output doorCommand, obstruct,
    input  doors, pressurize, depressurize, busy, cmd_reject, obstruct_fault
  );
  modport slave (
    input  doorCommand, obstruct,
    output doors, pressurize, depressurize, busy, cmd_reject, obstruct_fault
  );
`else
  modport master (
    output doorCommand,
    input  doors, pressurize, depressurize, busy, cmd_reject
  );
  modport slave (
    input  doorCommand,
    output doors, pressurize, depressurize, busy, cmd_reject
  );
`endif
endinterface

// File: rtl/airlock_plant.sv
// Airlock actuator/plant: executes door and pump commands with timed travel
// and enforces the door/pressure safety interlocks on its own.
// Optional macro: AIRLOCK_OBSTRUCT_EN (obstruction on a closing door reverses it).
module airlock_plant #(
  parameter logic [24:0] TICK_DIV  = 25'd25000000,
  parameter logic [3:0]  DOOR_TIME = 4'd2,
  parameter logic [3:0]  PUMP_TIME = 4'd4
) (
  input  logic            clk,
  input  logic            rst,
  airlock_plant_if.slave  bus
);

  // Zero-valued times behave as one unit so motion always ends.
  localparam logic [24:0] TICK_MAX = (TICK_DIV == 25'd0) ? 25'd0 : TICK_DIV - 25'd1;
  localparam logic [3:0]  DOOR_T   = (DOOR_TIME == 4'd0) ? 4'd1 : DOOR_TIME;
  localparam logic [3:0]  PUMP_T   = (PUMP_TIME == 4'd0) ? 4'd1 : PUMP_TIME;

  typedef enum logic [1:0] {IDLE, MOVE_INNER, MOVE_OUTER, PUMP} state_t;

  typedef enum logic [2:0] {
    CMD_IDLE      = 3'b000,
    CMD_CLOSE_IN  = 3'b001,
    CMD_OPEN_IN   = 3'b010,
    CMD_CLOSE_OUT = 3'b011,
    CMD_OPEN_OUT  = 3'b100,
    CMD_DEPRESS   = 3'b101,
    CMD_PRESS     = 3'b110,
    CMD_RSVD      = 3'b111
  } cmd_t;

  state_t      r_state;
  logic        r_dir;        // 1 = opening, 0 = closing
  logic        r_ptgt;       // 1 = pressurize, 0 = depressurize
  logic [24:0] r_pre;
  logic [3:0]  r_cnt;
  logic [2:0]  r_last_cmd;
  logic [1:0]  r_doors;
  logic        r_press;
  logic        r_depress;
  logic        r_busy;
  logic        r_reject;
  logic        r_fault;

  logic        w_eval;
  logic        w_go_inner;
  logic        w_go_outer;
  logic        w_go_pump;
  logic        w_bad;
  logic        w_open;
  logic        w_ptgt;
  logic        w_tick;
  logic [3:0]  w_cnt_next;
  logic        w_done;
  logic        w_closing;
  logic        w_obstruct;
  logic        w_idx;

  assign w_tick     = (r_pre == TICK_MAX);
  assign w_cnt_next = r_cnt + 4'd1;
  assign w_done     = w_tick && (w_cnt_next == ((r_state == PUMP) ? PUMP_T : DOOR_T));
  assign w_closing  = ((r_state == MOVE_INNER) || (r_state == MOVE_OUTER)) && !r_dir;
  assign w_idx      = (r_state == MOVE_OUTER);

`ifdef AIRLOCK_OBSTRUCT_EN
  assign w_obstruct         = w_closing && bus.obstruct;
  assign bus.obstruct_fault = r_fault;
`else
  assign w_obstruct = 1'b0;
`endif

  // Decode a newly changed command in IDLE against the interlock rules.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    w_eval     = (r_state == IDLE) && (bus.doorCommand != r_last_cmd);
    w_go_inner = 1'b0;
    w_go_outer = 1'b0;
    w_go_pump  = 1'b0;
    w_bad      = 1'b0;
    w_open     = 1'b0;
    w_ptgt     = 1'b0;
    if (w_eval) begin
      case (bus.doorCommand)
        CMD_CLOSE_IN:  w_go_inner = r_doors[0];
        CMD_OPEN_IN:
          if (!r_doors[0]) begin
            if (!r_doors[1] && r_press) begin
              w_go_inner = 1'b1;
              w_open     = 1'b1;
            end else begin
              w_bad = 1'b1;
            end
          end
        CMD_CLOSE_OUT: w_go_outer = r_doors[1];
        CMD_OPEN_OUT:
          if (!r_doors[1]) begin
            if (!r_doors[0] && r_depress) begin
              w_go_outer = 1'b1;
              w_open     = 1'b1;
            end else begin
              w_bad = 1'b1;
            end
          end
        CMD_DEPRESS:
          if (!r_depress) begin
            if (r_doors == 2'b00) w_go_pump = 1'b1;
            else                  w_bad     = 1'b1;
          end
        CMD_PRESS:
          if (!r_press) begin
            if (r_doors == 2'b00) begin
              w_go_pump = 1'b1;
              w_ptgt    = 1'b1;
            end else begin
              w_bad = 1'b1;
            end
          end
        default: ;  // CMD_IDLE and CMD_RSVD are no-ops
      endcase
    end
  end

  // Main sequencer: command acceptance, timed motion and registered status.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the last
    // assignment in program order wins within one clock.
    if (!rst) begin
      r_state    <= IDLE;
      r_dir      <= 1'b0;
      r_ptgt     <= 1'b1;
      r_pre      <= '0;
      r_cnt      <= '0;
      r_last_cmd <= CMD_IDLE;
      r_doors    <= 2'b00;
      r_press    <= 1'b1;
      r_depress  <= 1'b0;
      r_busy     <= 1'b0;
      r_reject   <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      r_fault  <= 1'b0;
      if (w_eval) r_last_cmd <= bus.doorCommand;

      if (r_state != IDLE) begin
        if (w_tick) begin
          r_pre <= '0;
          r_cnt <= w_cnt_next;
        end else begin
          r_pre <= r_pre + 25'd1;
        end
      end

      case (r_state)
        IDLE: begin
          r_reject <= w_bad;
          if (w_go_inner || w_go_outer || w_go_pump) begin
            r_pre  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_dir  <= w_open;
          end
          if (w_go_inner) begin
            r_state <= MOVE_INNER;
            if (w_open) r_doors[0] <= 1'b1;
          end
          if (w_go_outer) begin
            r_state <= MOVE_OUTER;
            if (w_open) r_doors[1] <= 1'b1;
          end
          if (w_go_pump) begin
            r_state   <= PUMP;
            r_ptgt    <= w_ptgt;
            r_press   <= 1'b0;
            r_depress <= 1'b0;
          end
        end
        MOVE_INNER, MOVE_OUTER: begin
          if (w_obstruct) begin
            // Reverse to opening; the door bit is already 1 while closing.
            r_dir   <= 1'b1;
            r_pre   <= '0;
            r_cnt   <= '0;
            r_fault <= 1'b1;
          end else if (w_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (!r_dir) r_doors[w_idx] <= 1'b0;
          end
        end
        PUMP: begin
          if (w_done) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_press   <= r_ptgt;
            r_depress <= !r_ptgt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.doors        = r_doors;
  assign bus.pressurize   = r_press;
  assign bus.depressurize = r_depress;
  assign bus.busy         = r_busy;
  assign bus.cmd_reject   = r_reject;

endmodule

// File: tb/tb_airlock_plant.sv
// Scoreboard bench for airlock_plant (TICK_DIV=4, DOOR_TIME=2, PUMP_TIME=3).
// Stimulus pushes expected status vectors tagged with a cycle; a monitor on
// the falling edge pops and compares them, plus per-cycle safety invariants.
module tb_airlock_plant;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic w_fault;

  airlock_plant_if bus ();

  airlock_plant #(
    .TICK_DIV  (25'd4),
    .DOOR_TIME (4'd2),
    .PUMP_TIME (4'd3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef AIRLOCK_OBSTRUCT_EN
  assign w_fault = bus.obstruct_fault;
`else
  assign w_fault = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Expected vector layout: {fault, doors[1:0], pressurize, depressurize, busy, cmd_reject}
  typedef struct {
    int          at;
    string       name;
    logic [6:0]  exp;
  } exp_t;

  exp_t q[$];

  function automatic logic [6:0] st(logic [1:0] d, logic p, logic dp, logic b, logic r, logic f);
    return {f, d, p, dp, b, r};
  endfunction

  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_at(int off, string name, logic [6:0] e);
    exp_t item;
    item.at   = cyc + off;
    item.name = name;
    item.exp  = e;
    q.push_back(item);
  endtask

  // Monitor: safety invariants every cycle, then any expectations due now.
  always @(negedge clk) begin
    logic [6:0] act;
    act = {w_fault, bus.doors, bus.pressurize, bus.depressurize, bus.busy, bus.cmd_reject};
    check("inv_doors_not_11", {6'd0, bus.doors == 2'b11}, 7'd0);
    check("inv_flags_exclusive", {6'd0, bus.pressurize && bus.depressurize}, 7'd0);
    check("inv_pump_doors_closed",
          {6'd0, bus.busy && !bus.pressurize && !bus.depressurize && (bus.doors != 2'b00)}, 7'd0);
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at <= cyc) begin
        check(q[i].name, act, q[i].exp);
        q.delete(i);
      end
    end
  end

  initial begin
    int guard;
    bus.doorCommand = 3'b000;
`ifdef AIRLOCK_OBSTRUCT_EN
    bus.obstruct = 1'b0;
`endif

    // Reset values
    @(negedge clk);
    expect_at(1, "reset_state", st(2'b00, 1, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Open inner: doors=01 one cycle after the edge, busy for 8 cycles
    bus.doorCommand = 3'b010;
    expect_at(1, "open_in_start", st(2'b01, 1, 0, 1, 0, 0));
    expect_at(8, "open_in_busy8", st(2'b01, 1, 0, 1, 0, 0));
    expect_at(9, "open_in_done",  st(2'b01, 1, 0, 0, 0, 0));
    repeat (10) @(negedge clk);

    // Open outer with inner open: single reject pulse, no repeat while held
    bus.doorCommand = 3'b100;
    expect_at(1, "rej_open_out", st(2'b01, 1, 0, 0, 1, 0));
    for (int k = 2; k <= 21; k++) expect_at(k, "rej_open_out_hold", st(2'b01, 1, 0, 0, 0, 0));
    repeat (21) @(negedge clk);

    // Close inner, then depressurize in the first idle cycle
    bus.doorCommand = 3'b001;
    expect_at(1, "close_in_start", st(2'b01, 1, 0, 1, 0, 0));
    expect_at(8, "close_in_busy8", st(2'b01, 1, 0, 1, 0, 0));
    expect_at(9, "close_in_done",  st(2'b00, 1, 0, 0, 0, 0));
    repeat (9) @(negedge clk);
    bus.doorCommand = 3'b101;
    expect_at(1,  "depress_start",  st(2'b00, 0, 0, 1, 0, 0));
    expect_at(12, "depress_busy12", st(2'b00, 0, 0, 1, 0, 0));
    expect_at(13, "depress_done",   st(2'b00, 0, 1, 0, 0, 0));
    repeat (13) @(negedge clk);

    // Open outer now legal
    bus.doorCommand = 3'b100;
    expect_at(1, "open_out_start", st(2'b10, 0, 1, 1, 0, 0));
    expect_at(8, "open_out_busy8", st(2'b10, 0, 1, 1, 0, 0));
    expect_at(9, "open_out_done",  st(2'b10, 0, 1, 0, 0, 0));
    repeat (10) @(negedge clk);

    // Pressurize with outer open: rejected, flags unchanged
    bus.doorCommand = 3'b110;
    expect_at(1, "rej_press", st(2'b10, 0, 1, 0, 1, 0));
    expect_at(2, "rej_press_after", st(2'b10, 0, 1, 0, 0, 0));
    repeat (3) @(negedge clk);

    // Close outer, then pressurize and reset mid-pump
    bus.doorCommand = 3'b011;
    expect_at(1, "close_out_start", st(2'b10, 0, 1, 1, 0, 0));
    expect_at(9, "close_out_done",  st(2'b00, 0, 1, 0, 0, 0));
    repeat (10) @(negedge clk);
    bus.doorCommand = 3'b110;
    expect_at(1, "press_start", st(2'b00, 0, 0, 1, 0, 0));
    expect_at(4, "press_busy4", st(2'b00, 0, 0, 1, 0, 0));
    repeat (4) @(negedge clk);
    rst = 1'b0;
    bus.doorCommand = 3'b000;
    expect_at(1, "mid_pump_reset", st(2'b00, 1, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    expect_at(1, "post_reset_idle", st(2'b00, 1, 0, 0, 0, 0));
    expect_at(3, "post_reset_idle3", st(2'b00, 1, 0, 0, 0, 0));
    repeat (4) @(negedge clk);

`ifdef AIRLOCK_OBSTRUCT_EN
    // Obstruction during an inner close reverses it to opening
    bus.doorCommand = 3'b010;
    expect_at(9, "obs_pre_open", st(2'b01, 1, 0, 0, 0, 0));
    repeat (10) @(negedge clk);
    bus.doorCommand = 3'b001;
    expect_at(1,  "obs_close_start", st(2'b01, 1, 0, 1, 0, 0));
    expect_at(3,  "obs_fault_pulse", st(2'b01, 1, 0, 1, 0, 1));
    expect_at(4,  "obs_fault_clear", st(2'b01, 1, 0, 1, 0, 0));
    expect_at(10, "obs_busy_hold",   st(2'b01, 1, 0, 1, 0, 0));
    expect_at(11, "obs_done_open",   st(2'b01, 1, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    bus.obstruct = 1'b1;
    @(negedge clk);
    bus.obstruct = 1'b0;
    repeat (10) @(negedge clk);
`endif

    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("scoreboard_drain", 7'(q.size()), 7'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
